l1_cache_ctrl: RTL and testbench
================================

Name: l1_cache_ctrl

Overview:
- Blocking, write-back, write-allocate controller for the direct-mapped L1.
- Owns the line storage: 64 lines of 32-bit data, plus a 4-bit tag, a valid bit and a dirty bit per line.
- Sits between one CPU requester and the main-memory port. Sequences hit service, dirty-victim writeback and line refill through one FSM.

Parameters:
- MM_BLOCK_COUNT, 1024, main-memory blocks; address width AW = $clog2(MM_BLOCK_COUNT) = 10.
- L1_BLOCK_COUNT, 64, cache lines; index width IW = $clog2(L1_BLOCK_COUNT) = 6.
- TAG_BITS, AW-IW = 4, tag width.
- DATA_WIDTH, 32, data width of one block.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU request valid; held by CPU until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  block address; index = [IW-1:0], tag = [AW-1:IW].
- cpu_wdata  in  DATA_WIDTH  write data.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_WIDTH  read data; valid while cpu_ready = 1, holds its value otherwise.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = writeback, 0 = refill read.
- mem_addr  out  AW  memory block address.
- mem_wdata  out  DATA_WIDTH  writeback data.
- mem_ack  in  1  memory done; refill data is valid on mem_rdata in the same cycle.
- mem_rdata  in  DATA_WIDTH  refill data.

Behaviour:
- Reset (synchronous, active-high)
  - state = IDLE.
  - All valid, dirty, tag and data entries cleared to 0.
  - cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr and mem_wdata all 0.
  - Reset mid-transaction abandons it; mem_req is 0 in the cycle after reset is sampled.
- IDLE
  - If cpu_req = 1: latch addr, we and wdata into request registers, go to COMPARE.
  - cpu_req is sampled only in IDLE and ignored in all other states.
- COMPARE (hit test uses latched idx/tag): hit = valid[idx] && tag[idx] == tag.
  - Hit, read: cpu_rdata <= data[idx].
  - Hit, write: data[idx] <= wdata and dirty[idx] <= 1.
  - On any hit: cpu_ready = 1 for one cycle, then go to IDLE.
  - Hit latency: accepted at edge N, cpu_ready high at edge N+1.
  - Miss with valid[idx] && dirty[idx]: go to WRITEBACK.
  - Miss otherwise: go to ALLOCATE.
- WRITEBACK
  - Drive mem_req = 1, mem_we = 1, mem_addr = {tag[idx], idx}, mem_wdata = data[idx].
  - On mem_ack: dirty[idx] <= 0, go to ALLOCATE.
- ALLOCATE
  - Drive mem_req = 1, mem_we = 0, mem_addr = latched addr.
  - On mem_ack: data[idx] <= mem_rdata, tag[idx] <= tag, valid[idx] <= 1, dirty[idx] <= 0, go to COMPARE. The re-compare is guaranteed to hit and applies any pending write.
- Memory handshake rules
  - mem_ack is honoured only while mem_req = 1; a stray ack is ignored.
  - Ack may arrive in the first cycle of mem_req (zero wait).
  - mem_req is deasserted in the cycle after the ack, except WRITEBACK -> ALLOCATE: mem_req stays high, and mem_we and mem_addr change on that edge.
  - mem_addr, mem_we and mem_wdata are stable for as long as mem_req is held.
- Address boundaries: addr 0x000 and 0x3FF are handled identically; no special cases.
- Miss latency (mem_ack after W cycles per access):
  - Clean miss: 3 + W cycles to cpu_ready.
  - Dirty miss: 4 + 2W cycles to cpu_ready.
- A write miss to a clean line performs a refill, then merges the write in COMPARE and sets dirty.
- States are encoded in 3 bits: IDLE, COMPARE, WRITEBACK, ALLOCATE. Unused encodings go to IDLE.

Optional Feature:
- Macro: L1_PERF_CNT_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], both cleared by reset.
  - hit_count increments once per first-pass COMPARE hit.
  - miss_count increments once per COMPARE miss.
  - The re-compare after refill is not counted.
  - Both counters wrap 0xFFFFFFFF -> 0.
- Not defined: the ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Cold read 0x045 (idx 5, tag 1), mem_rdata 0xDEADBEEF, ack after 2 cycles -> mem_req with mem_we = 0, mem_addr = 0x045; then cpu_ready with cpu_rdata = 0xDEADBEEF.
- Repeat read 0x045 -> cpu_ready one cycle after acceptance, data 0xDEADBEEF, mem_req never asserted.
- Write 0x045 with 0x12345678, then read 0x085 (idx 5, tag 2) -> WRITEBACK with mem_addr = 0x045, mem_wdata = 0x12345678, mem_we = 1; then ALLOCATE with mem_addr = 0x085; cpu_rdata = refill value.
- Write miss to 0x3FF with 0xA5A5A5A5, zero-wait ack -> refill read from 0x3FF; then a read of 0x3FF returns 0xA5A5A5A5 as a hit; a later conflict on 0x3FF forces a writeback of 0xA5A5A5A5.
- Assert reset while in ALLOCATE with the ack withheld -> next cycle mem_req = 0, cpu_ready = 0, state IDLE; a read of 0x045 then misses (valid cleared).
- With L1_PERF_CNT_EN: miss, hit, hit, dirty miss sequence -> hit_count = 2, miss_count = 2.

Source files
------------

// File: rtl/l1_cache_ctrl.sv
// -----------------------------------------------------------------------------
// l1_cache_ctrl
//
// Blocking, write-back, write-allocate controller for a direct-mapped L1 with
// 64 lines of 32-bit data. Each line also has a 4-bit tag, a valid bit and a
// dirty bit. One FSM (IDLE, COMPARE, WRITEBACK, ALLOCATE) sequences three
// things: hit service, writeback of a dirty victim, and line refill.
//
// Handshakes:
//   cpu side : the CPU holds cpu_req (with we/addr/wdata) until it sees
//              cpu_ready. cpu_ready is a one-cycle pulse. cpu_req is only
//              sampled in IDLE.
//   mem side : mem_req is held, with stable mem_we/mem_addr/mem_wdata, until
//              mem_ack is sampled high. mem_ack is ignored while mem_req = 0.
//              Refill data on mem_rdata is taken in the ack cycle.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      CPU request (addr = {tag, index})
//   cpu_ready, cpu_rdata       completion pulse and read data (rdata holds)
//   mem_req/we/addr/wdata      memory request (we=1 writeback, we=0 refill)
//   mem_ack, mem_rdata         memory completion and refill data
//   dbg_state                  current FSM state, for observation
//   hit_count, miss_count      performance counters (L1_PERF_CNT_EN only)
//
// Build option:
//   L1_PERF_CNT_EN  adds the hit_count/miss_count outputs. A hit is counted
//                   only on the first-pass compare; the compare that follows
//                   a refill is not counted.
// -----------------------------------------------------------------------------
module l1_cache_ctrl #(
    parameter int  MM_BLOCK_COUNT = 1024,
    parameter int  L1_BLOCK_COUNT = 64,
    parameter int  DATA_WIDTH     = 32,
    localparam int AW             = $clog2(MM_BLOCK_COUNT),
    localparam int IW             = $clog2(L1_BLOCK_COUNT),
    localparam int TAG_BITS       = AW - IW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [AW-1:0]         cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
`ifdef L1_PERF_CNT_EN
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
`endif
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        WRITEBACK = 3'd2,
        ALLOCATE  = 3'd3
    } state_t;

    state_t state;

    // Line storage
    logic [DATA_WIDTH-1:0] data_mem [L1_BLOCK_COUNT];
    logic [TAG_BITS-1:0]   tag_mem  [L1_BLOCK_COUNT];
    logic [L1_BLOCK_COUNT-1:0] valid_bits;
    logic [L1_BLOCK_COUNT-1:0] dirty_bits;

    // Latched request
    logic [AW-1:0]         req_addr;
    logic                  req_we;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic [IW-1:0]       req_idx;
    logic [TAG_BITS-1:0] req_tag;
    logic                hit;
    logic                victim_dirty;
    logic                mem_done;

    assign req_idx      = req_addr[IW-1:0];
    assign req_tag      = req_addr[AW-1:IW];
    assign hit          = valid_bits[req_idx] && (tag_mem[req_idx] == req_tag);
    assign victim_dirty = valid_bits[req_idx] && dirty_bits[req_idx];
    // An ack only counts while a request is actually outstanding.
    assign mem_done     = mem_req && mem_ack;
    assign dbg_state    = state;

`ifdef L1_PERF_CNT_EN
    // Set when COMPARE is re-entered after a refill, so that hit is not counted.
    logic refill_pass;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cpu_ready  <= 1'b0;
            cpu_rdata  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            req_addr   <= '0;
            req_we     <= 1'b0;
            req_wdata  <= '0;
            valid_bits <= '0;
            dirty_bits <= '0;
            for (int i = 0; i < L1_BLOCK_COUNT; i++) begin
                data_mem[i] <= '0;
                tag_mem[i]  <= '0;
            end
`ifdef L1_PERF_CNT_EN
            refill_pass <= 1'b0;
            hit_count   <= '0;
            miss_count  <= '0;
`endif
        end else begin
            cpu_ready <= 1'b0;

            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_addr  <= cpu_addr;
                        req_we    <= cpu_we;
                        req_wdata <= cpu_wdata;
                        state     <= COMPARE;
                    end
                end

                COMPARE: begin
                    if (hit) begin
                        if (req_we) begin
                            data_mem[req_idx]   <= req_wdata;
                            dirty_bits[req_idx] <= 1'b1;
                        end else begin
                            cpu_rdata <= data_mem[req_idx];
                        end
                        cpu_ready <= 1'b1;
                        state     <= IDLE;
`ifdef L1_PERF_CNT_EN
                        if (!refill_pass) begin
                            hit_count <= hit_count + 32'd1;
                        end
                        refill_pass <= 1'b0;
`endif
                    end else begin
                        // Memory outputs are set up here so that mem_req
                        // is registered and stable from its first cycle.
                        mem_req <= 1'b1;
`ifdef L1_PERF_CNT_EN
                        miss_count <= miss_count + 32'd1;
`endif
                        if (victim_dirty) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_mem[req_idx], req_idx};
                            mem_wdata <= data_mem[req_idx];
                            state     <= WRITEBACK;
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= req_addr;
                            state    <= ALLOCATE;
                        end
                    end
                end

                WRITEBACK: begin
                    if (mem_done) begin
                        // mem_req stays high and moves straight to the refill.
                        dirty_bits[req_idx] <= 1'b0;
                        mem_we              <= 1'b0;
                        mem_addr            <= req_addr;
                        state               <= ALLOCATE;
                    end
                end

                ALLOCATE: begin
                    if (mem_done) begin
                        data_mem[req_idx]   <= mem_rdata;
                        tag_mem[req_idx]    <= req_tag;
                        valid_bits[req_idx] <= 1'b1;
                        dirty_bits[req_idx] <= 1'b0;
                        mem_req             <= 1'b0;
                        state               <= COMPARE;
`ifdef L1_PERF_CNT_EN
                        refill_pass <= 1'b1;
`endif
                    end
                end

                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for l1_cache_ctrl.
// The reference model treats the cache as transparent: a flat array holds the
// value the CPU must see at every address. A second small table of
// valid/tag/dirty per index predicts which memory transactions occur and what
// each one carries. A separate memory responder owns the main-memory array.
// -----------------------------------------------------------------------------
module tb_l1_cache_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req, cpu_we;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [2:0]  dbg_state;
`ifdef L1_PERF_CNT_EN
    logic [31:0] hit_count, miss_count;
`endif

    l1_cache_ctrl dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
`ifdef L1_PERF_CNT_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mem  [1024];   // main memory, owned by the responder
    logic [31:0] flat [1024];   // value the CPU must observe per address
    bit          mv   [64];
    logic [3:0]  mt   [64];
    bit          md   [64];
    logic [31:0] last_rd;
    int          m_hits, m_misses;

    // scoreboard queues
    logic [31:0] exp_q [$];
    logic        exp_we_q [$];
    logic [9:0]  exp_addr_q [$];
    logic [31:0] exp_wd_q [$];

    int          mem_wait = 0;
    bit          stray_en = 1'b1;
    logic [31:0] got_rdata;
    int          got_lat;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            mv[i] = 1'b0; md[i] = 1'b0; mt[i] = 4'd0;
        end
        for (int i = 0; i < 1024; i++) flat[i] = mem[i];
        last_rd  = 32'd0;
        m_hits   = 0;
        m_misses = 0;
        exp_q.delete(); exp_we_q.delete(); exp_addr_q.delete(); exp_wd_q.delete();
    endtask

    // ---------------- memory responder ----------------
    int rsp_cnt = 0;
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (mem_req) begin
                if (rsp_cnt >= mem_wait) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    rsp_cnt   = 0;
                end else begin
                    mem_ack = 1'b0;
                    rsp_cnt++;
                end
            end else begin
                rsp_cnt   = 0;
                mem_ack   = stray_en && ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // ---------------- compare process ----------------
    logic        hold_prev = 1'b0;
    logic        p_we;
    logic [9:0]  p_addr;
    logic [31:0] p_wd;
    logic        e_we;
    logic [9:0]  e_addr;
    logic [31:0] e_wd;

    always @(negedge clk) begin
        if (reset) begin
            hold_prev = 1'b0;
        end else begin
            if (cpu_ready) begin
                if (exp_q.size() == 0) check("cpu_ready_unexpected", 64'(cpu_ready), 64'd0);
                else check("cpu_rdata", 64'(cpu_rdata), 64'(exp_q.pop_front()));
            end
            if (mem_req && mem_ack) begin
                if (exp_we_q.size() == 0) begin
                    check("mem_req_unexpected", 64'(mem_req), 64'd0);
                end else begin
                    e_we   = exp_we_q.pop_front();
                    e_addr = exp_addr_q.pop_front();
                    e_wd   = exp_wd_q.pop_front();
                    check("mem_we", 64'(mem_we), 64'(e_we));
                    check("mem_addr", 64'(mem_addr), 64'(e_addr));
                    if (e_we) check("mem_wdata", 64'(mem_wdata), 64'(e_wd));
                end
            end
            if (hold_prev && mem_req)
                check("mem_hold_stable", 64'({mem_we, mem_addr, mem_wdata}), 64'({p_we, p_addr, p_wd}));
            hold_prev = mem_req && !mem_ack;
            p_we      = mem_we;
            p_addr    = mem_addr;
            p_wd      = mem_wdata;
        end
    end

    // ---------------- driver tasks ----------------
    // Called #1 after a rising edge; returns #1 after the edge that shows cpu_ready.
    task automatic do_req(input logic we, input logic [9:0] addr, input logic [31:0] wd, input int w);
        logic [5:0] idx;
        logic [3:0] tg;
        logic [9:0] vic;
        bit         hit, dirty_vic;
        int         exp_lat, lat;
        idx       = addr[5:0];
        tg        = addr[9:6];
        hit       = mv[idx] && (mt[idx] == tg);
        dirty_vic = !hit && mv[idx] && md[idx];
        mem_wait  = w;
        if (!hit) begin
            m_misses++;
            if (dirty_vic) begin
                vic = {mt[idx], idx};
                exp_we_q.push_back(1'b1); exp_addr_q.push_back(vic); exp_wd_q.push_back(flat[vic]);
            end
            exp_we_q.push_back(1'b0); exp_addr_q.push_back(addr); exp_wd_q.push_back(32'd0);
            mv[idx] = 1'b1; mt[idx] = tg; md[idx] = 1'b0;
            exp_lat = dirty_vic ? 4 + 2 * w : 3 + w;
        end else begin
            m_hits++;
            exp_lat = 1;
        end
        if (we) begin
            md[idx]    = 1'b1;
            flat[addr] = wd;
        end else begin
            last_rd = flat[addr];
        end
        exp_q.push_back(last_rd);

        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!cpu_ready && lat < 60);
        got_rdata = cpu_rdata;
        got_lat   = lat;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 10'd0; cpu_wdata = 32'd0;
        check("latency", 64'(lat), 64'(exp_lat));
    endtask

    // Applies reset for one edge and checks the cleared outputs.
    task automatic do_reset();
        reset   = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        check("rst_cpu_ready", 64'(cpu_ready), 64'd0);
        check("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
`ifdef L1_PERF_CNT_EN
        check("rst_hit_count", 64'(hit_count), 64'd0);
        check("rst_miss_count", 64'(miss_count), 64'd0);
`endif
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    logic [5:0] r_idx;
    logic [3:0] r_tag;

    initial begin
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 10'd0; cpu_wdata = 32'd0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[10'h045] = 32'hDEADBEEF;
        @(posedge clk); #1;
        do_reset();

        // cold read, then a repeat hit
        do_req(1'b0, 10'h045, 32'd0, 2);
        check("cold_rdata", 64'(got_rdata), 64'h0000_0000_DEAD_BEEF);
        check("cold_lat", 64'(got_lat), 64'd5);
        do_req(1'b0, 10'h045, 32'd0, 3);
        check("hit_rdata", 64'(got_rdata), 64'h0000_0000_DEAD_BEEF);
        check("hit_lat", 64'(got_lat), 64'd1);

        // write hit, then a conflicting read forces a writeback
        do_req(1'b1, 10'h045, 32'h1234_5678, 1);
        do_req(1'b0, 10'h085, 32'd0, 1);
        check("wb_mem_045", 64'(mem[10'h045]), 64'h0000_0000_1234_5678);
        check("dirty_miss_lat", 64'(got_lat), 64'd6);

        // write miss at the top address with zero-wait ack
        do_req(1'b1, 10'h3FF, 32'hA5A5_A5A5, 0);
        check("wmiss_lat", 64'(got_lat), 64'd3);
        do_req(1'b0, 10'h3FF, 32'd0, 2);
        check("wmiss_readback", 64'(got_rdata), 64'h0000_0000_A5A5_A5A5);
        do_req(1'b0, 10'h1FF, 32'd0, 0);
        check("wb_mem_3ff", 64'(mem[10'h3FF]), 64'h0000_0000_A5A5_A5A5);

        // bottom address
        do_req(1'b1, 10'h000, 32'h0BAD_CAFE, 1);
        do_req(1'b0, 10'h000, 32'd0, 1);
        check("addr0_rdata", 64'(got_rdata), 64'h0000_0000_0BAD_CAFE);

        // reset while ALLOCATE waits on a withheld ack
        mem_wait = 1000;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h105;
        for (int i = 0; i < 20 && !mem_req; i++) begin
            @(posedge clk); #1;
        end
        check("alloc_req_seen", 64'(mem_req), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        mem_wait = 0;

        // valid bits were cleared: 0x045 misses and returns the written-back value
        do_req(1'b0, 10'h045, 32'd0, 1);
        check("post_rst_lat", 64'(got_lat), 64'd4);
        check("post_rst_rdata", 64'(got_rdata), 64'h0000_0000_1234_5678);
        do_req(1'b0, 10'h045, 32'd0, 0);
        do_req(1'b1, 10'h045, 32'h55AA_55AA, 0);
        do_req(1'b0, 10'h085, 32'd0, 2);
        check("perf_seq_lat", 64'(got_lat), 64'd8);
`ifdef L1_PERF_CNT_EN
        check("perf_hit_count", 64'(hit_count), 64'd2);
        check("perf_miss_count", 64'(miss_count), 64'd2);
`endif

        // randomized traffic concentrated on a few indices to force conflicts
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0:       r_idx = 6'd0;
                1:       r_idx = 6'd63;
                2:       r_idx = 6'($urandom_range(0, 3));
                default: r_idx = 6'($urandom_range(0, 63));
            endcase
            r_tag = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 2));
            do_req(1'($urandom_range(0, 1)), {r_tag, r_idx}, $urandom, int'($urandom_range(0, 3)));
        end
`ifdef L1_PERF_CNT_EN
        check("rand_hit_count", 64'(hit_count), 64'(m_hits));
        check("rand_miss_count", 64'(miss_count), 64'(m_misses));
`endif

        repeat (2) @(posedge clk);
        #1;
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("exp_mem_drained", 64'(exp_we_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
